// File: rtl/esfa_benchmark_sequencer.sv
// Benchmark campaign controller: issues NUM_RUNS start pulses to one datapath,
// times out stalled runs, and tallies failures and active cycles.
module esfa_benchmark_sequencer #(
  parameter int NUM_RUNS = 16,
  parameter int RUN_W    = 8,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             doRun,
  output logic             dutStart,
  input  logic             dutDone,
  input  logic             dutPass,
  output logic             isRunning,
  output logic             wasSuccessful,
  output logic             timedOut,
  output logic [RUN_W-1:0] runIndex,
  output logic [RUN_W-1:0] failCount,
  output logic [CNT_W-1:0] cycleCount
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(NUM_RUNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [RUN_W-1:0] fail_reg, fail_next;
  logic [CNT_W-1:0] cyc_reg, cyc_next;
  logic             timed_reg, timed_next;
  logic             success_reg, success_next;
  logic             active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      run_reg     <= '0;
      fail_reg    <= '0;
      cyc_reg     <= '0;
      timed_reg   <= 1'b0;
      success_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      run_reg     <= run_next;
      fail_reg    <= fail_next;
      cyc_reg     <= cyc_next;
      timed_reg   <= timed_next;
      success_reg <= success_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    run_next     = run_reg;
    fail_next    = fail_reg;
    cyc_next     = cyc_reg;
    timed_next   = timed_reg;
    success_next = success_reg;
    active       = (state_reg == S_LAUNCH) || (state_reg == S_WAIT) || (state_reg == S_CHECK);

    if (active && (cyc_reg != '1)) begin
      cyc_next = cyc_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (doRun) begin
          state_next   = S_LAUNCH;
          run_next     = '0;
          fail_next    = '0;
          cyc_next     = '0;
          timed_next   = 1'b0;
          success_next = 1'b0;
        end
      end
      S_LAUNCH: begin
        timer_next = '0;
        state_next = doRun ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        timer_next = timer_reg + 1'b1;
        // Abort outranks a completion arriving on the same cycle.
        if (!doRun) begin
          state_next   = S_IDLE;
          success_next = 1'b0;
        end else if (dutDone) begin
          if (!dutPass) begin
            fail_next = fail_reg + 1'b1;
          end
          state_next = S_CHECK;
        end else if (timer_reg == TMR_LAST) begin
          timed_next   = 1'b1;
          fail_next    = fail_reg + 1'b1;
          success_next = 1'b0;
          state_next   = S_DONE;
        end
      end
      S_CHECK: begin
        if (!doRun) begin
          state_next   = S_IDLE;
          success_next = 1'b0;
        end else if (run_reg == RUN_LAST) begin
          state_next   = S_DONE;
          success_next = (fail_reg == '0) && !timed_reg;
        end else begin
          run_next   = run_reg + 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_DONE: begin
        if (!doRun) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign dutStart      = (state_reg == S_LAUNCH);
  assign isRunning     = active;
  assign wasSuccessful = success_reg;
  assign timedOut      = timed_reg;
  assign runIndex      = run_reg;
  assign failCount     = fail_reg;
  assign cycleCount    = cyc_reg;

endmodule

// File: tb/tb_esfa_benchmark_sequencer.sv
// Directed bench for the benchmark sequencer with a latency-table datapath model.
module tb_esfa_benchmark_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        doRun = 1'b0;
  logic        dutStart;
  logic        dutDone = 1'b0;
  logic        dutPass = 1'b0;
  logic        isRunning;
  logic        wasSuccessful;
  logic        timedOut;
  logic [7:0]  runIndex;
  logic [7:0]  failCount;
  logic [31:0] cycleCount;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int base_cnt = 0;
  int start_cyc [8];
  int lat_tab [4];
  logic pass_tab [4];
  int wcnt = 0;
  int cur_lat = 0;
  logic cur_pass = 1'b0;
  logic model_active = 1'b0;
  int act;
  int n_before;

  esfa_benchmark_sequencer #(
    .NUM_RUNS(4), .RUN_W(8), .CNT_W(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .doRun(doRun), .dutStart(dutStart),
    .dutDone(dutDone), .dutPass(dutPass), .isRunning(isRunning),
    .wasSuccessful(wasSuccessful), .timedOut(timedOut), .runIndex(runIndex),
    .failCount(failCount), .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Datapath model: raises dutDone on WAIT cycle lat_tab[run]; latency 0 never answers.
  always @(negedge clk) begin
    dutDone = 1'b0;
    dutPass = 1'b0;
    if (reset) begin
      model_active = 1'b0;
    end else if (dutStart) begin
      int ridx;
      ridx = start_cnt - base_cnt;
      if (ridx >= 0 && ridx < 8) start_cyc[ridx] = cyc;
      cur_lat  = (ridx >= 0 && ridx < 4) ? lat_tab[ridx] : 3;
      cur_pass = (ridx >= 0 && ridx < 4) ? pass_tab[ridx] : 1'b1;
      start_cnt++;
      wcnt = 0;
      model_active = 1'b1;
    end else if (model_active) begin
      wcnt++;
      if (cur_lat != 0 && wcnt == cur_lat) begin
        dutDone = 1'b1;
        dutPass = cur_pass;
        model_active = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!isRunning) break;
      n++;
      tick(1);
    end
  endtask

  task automatic set_tabs(input int l0, l1, l2, l3, input logic p0, p1, p2, p3);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l3;
    pass_tab[0] = p0; pass_tab[1] = p1; pass_tab[2] = p2; pass_tab[3] = p3;
  endtask

  initial begin
    set_tabs(3, 3, 3, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(2);
    check("rst_running", isRunning, 0);
    check("rst_start", dutStart, 0);
    reset = 1'b0;
    base_cnt = start_cnt;
    tick(20);
    check("idle_starts", start_cnt - base_cnt, 0);
    check("idle_success", wasSuccessful, 0);
    check("idle_timeout", timedOut, 0);
    check("idle_runidx", runIndex, 0);
    check("idle_fail", failCount, 0);
    check("idle_cycles", cycleCount, 0);
    $display("step reset: idle outputs checked");

    // All runs pass with latency 3
    base_cnt = start_cnt;
    doRun = 1'b1;
    tick(1);
    check("A_launch_start", dutStart, 1);
    wait_done(act);
    check("A_active", act, 20);
    check("A_starts", start_cnt - base_cnt, 4);
    for (int k = 1; k < 4; k++) check("A_spacing", start_cyc[k] - start_cyc[k-1], 5);
    check("A_cycles", cycleCount, 20);
    check("A_fail", failCount, 0);
    check("A_runidx", runIndex, 3);
    check("A_success", wasSuccessful, 1);
    check("A_timeout", timedOut, 0);
    tick(10);
    check("A_hold_starts", start_cnt - base_cnt, 4);
    check("A_hold_running", isRunning, 0);
    $display("step pass campaign: act=%0d cycles=%0d", act, cycleCount);

    // Runs 1 and 3 fail
    doRun = 1'b0;
    tick(1);
    check("B_idle_held_success", wasSuccessful, 1);
    check("B_idle_held_cycles", cycleCount, 20);
    set_tabs(3, 3, 3, 3, 1'b1, 1'b0, 1'b1, 1'b0);
    base_cnt = start_cnt;
    doRun = 1'b1;
    tick(1);
    check("B_clear_cycles", cycleCount, 0);
    check("B_clear_success", wasSuccessful, 0);
    wait_done(act);
    check("B_active", act, 20);
    check("B_fail", failCount, 2);
    check("B_success", wasSuccessful, 0);
    check("B_timeout", timedOut, 0);
    $display("step fail campaign: fail=%0d", failCount);

    // Run 2 never answers
    doRun = 1'b0;
    tick(1);
    set_tabs(3, 3, 0, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    base_cnt = start_cnt;
    doRun = 1'b1;
    tick(1);
    check("C_clear_fail", failCount, 0);
    wait_done(act);
    check("C_active", act, 19);
    check("C_cycles", cycleCount, 19);
    check("C_timeout", timedOut, 1);
    check("C_fail", failCount, 1);
    check("C_runidx", runIndex, 2);
    check("C_success", wasSuccessful, 0);
    tick(5);
    check("C_starts", start_cnt - base_cnt, 3);
    $display("step timeout campaign: cycles=%0d", cycleCount);

    // Completion lands on the last allowed WAIT cycle
    doRun = 1'b0;
    tick(1);
    set_tabs(8, 3, 3, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    base_cnt = start_cnt;
    doRun = 1'b1;
    tick(1);
    check("D_clear_timeout", timedOut, 0);
    wait_done(act);
    check("D_cycles", cycleCount, 25);
    check("D_timeout", timedOut, 0);
    check("D_fail", failCount, 0);
    check("D_runidx", runIndex, 3);
    check("D_success", wasSuccessful, 1);
    $display("step boundary completion: cycles=%0d", cycleCount);

    // Abort in WAIT of run 1; its late failing completion must be ignored
    doRun = 1'b0;
    tick(1);
    set_tabs(3, 3, 3, 3, 1'b1, 1'b0, 1'b1, 1'b1);
    base_cnt = start_cnt;
    doRun = 1'b1;
    tick(7);
    check("E_pre_starts", start_cnt - base_cnt, 2);
    doRun = 1'b0;
    tick(1);
    check("E_running", isRunning, 0);
    check("E_success", wasSuccessful, 0);
    check("E_runidx", runIndex, 1);
    check("E_cycles", cycleCount, 7);
    tick(5);
    check("E_fail_ignored", failCount, 0);
    check("E_no_restart", start_cnt - base_cnt, 2);
    $display("step abort: runidx=%0d cycles=%0d", runIndex, cycleCount);

    // Reset during WAIT of run 2, then restart from run 0
    set_tabs(3, 3, 3, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    base_cnt = start_cnt;
    doRun = 1'b1;
    tick(12);
    check("F_pre_runidx", runIndex, 2);
    reset = 1'b1;
    #1;
    check("F_async_running", isRunning, 0);
    check("F_async_runidx", runIndex, 0);
    check("F_async_cycles", cycleCount, 0);
    n_before = start_cnt;
    tick(2);
    check("F_no_start_in_reset", start_cnt - n_before, 0);
    reset = 1'b0;
    base_cnt = start_cnt;
    tick(1);
    check("F_restart_start", dutStart, 1);
    check("F_restart_runidx", runIndex, 0);
    wait_done(act);
    check("F_active", act, 20);
    check("F_runidx", runIndex, 3);
    check("F_success", wasSuccessful, 1);
    $display("step reset restart: act=%0d", act);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esfa_benchmark_sequencer.md
Name: esfa_benchmark_sequencer

Overview:
- Controller that sequences a benchmark campaign over one ESFA design datapath instance.
- On `doRun`, it issues `NUM_RUNS` start pulses to the datapath, one at a time. After each pulse it waits for done/pass, enforces a per-run timeout, and counts failures and total active cycles.
- It reports `isRunning` and `wasSuccessful` to the benchmark harness.
- It sits between the top-level benchmark control (`doRun`) and the datapath start/done handshake.

Parameters:
- `NUM_RUNS`, 16, number of datapath operations per campaign; range 1 to 2^`RUN_W`-1.
- `RUN_W`, 8, width of `runIndex` and `failCount`.
- `CNT_W`, 32, width of `cycleCount`.
- `TIMEOUT`, 4096, maximum WAIT cycles per run before abort; must be ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `doRun`  in  1  level request; high starts a campaign from IDLE; low aborts or acknowledges.
- `dutStart`  out  1  one-cycle start pulse to the datapath.
- `dutDone`  in  1  one-cycle completion pulse from the datapath.
- `dutPass`  in  1  datapath result; valid only when `dutDone`=1.
- `isRunning`  out  1  high while the state is LAUNCH, WAIT or CHECK.
- `wasSuccessful`  out  1  high in DONE iff zero failures and no timeout.
- `timedOut`  out  1  sticky flag; a run exceeded `TIMEOUT`.
- `runIndex`  out  `RUN_W`  index of the current or last run.
- `failCount`  out  `RUN_W`  number of runs completed with `dutPass`=0.
- `cycleCount`  out  `CNT_W`  number of cycles spent in LAUNCH/WAIT/CHECK; saturating.

Behaviour:
- Reset (async, `reset`=1): state=IDLE; all outputs 0; internal wait timer 0.
- All outputs are registered. `isRunning` and `dutStart` are decoded from the registered state.
- IDLE:
  - If `doRun`=1, go to LAUNCH next cycle.
  - In the same transition clear `runIndex`, `failCount`, `cycleCount`, `timedOut` and `wasSuccessful`.
  - Results from the previous campaign are held in IDLE until the next start.
- LAUNCH:
  - `dutStart`=1 for exactly this cycle.
  - Wait timer cleared; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If `dutDone`=1: if `dutPass`=0, increment `failCount`; go to CHECK.
  - Else if timer = `TIMEOUT`-1: `timedOut`=1, `failCount`+1, go to DONE. The campaign is aborted.
  - If `dutDone` and the timeout fall on the same cycle, `dutDone` wins and no timeout is recorded.
- CHECK:
  - If `runIndex` = `NUM_RUNS`-1, go to DONE.
  - Otherwise `runIndex`+1 and go to LAUNCH.
- DONE:
  - `isRunning`=0.
  - `wasSuccessful` = (`failCount`==0 && !`timedOut`), registered on entry.
  - Stay in DONE while `doRun`=1. On `doRun`=0, go to IDLE with results held.
  - A new campaign therefore needs `doRun` to go low, then high again.
- Abort: `doRun`=0 during LAUNCH/WAIT/CHECK forces IDLE next cycle. `wasSuccessful`=0; counters keep their values; a pending `dutDone` that cycle is ignored.
- `cycleCount` increments on every cycle whose state is LAUNCH, WAIT or CHECK, and saturates at 2^`CNT_W`-1.
- `dutDone` outside WAIT is ignored and does not affect counters.
- Run timing, with datapath latency L ≥ 1 = number of WAIT cycles up to and including the one with `dutDone`:
  - one run = 1 (LAUNCH) + L (WAIT) + 1 (CHECK) cycles;
  - a full campaign = `NUM_RUNS`*(L+2) cycles.
- `failCount` never wraps because `NUM_RUNS` ≤ 2^`RUN_W`-1.
- Reset asserted mid-campaign returns everything to reset values immediately. No `dutStart` is issued while `reset`=1.

Test Plan:
- Reset checks:
  - `reset`=1, then release with `doRun`=0 → all outputs 0, state IDLE, no `dutStart` for 20 cycles.
  - Assert `reset` during WAIT of run 2 → `isRunning`=0 and `runIndex`=0 asynchronously. After release with `doRun`=1, the campaign restarts from run 0.
- `NUM_RUNS`=4, datapath model raises `dutDone`/`dutPass`=1 at WAIT cycle 3, `doRun` held 1 → exactly 4 `dutStart` pulses spaced 5 cycles apart. Final state: `cycleCount`=20, `failCount`=0, `runIndex`=3, `wasSuccessful`=1, `timedOut`=0.
- Same setup with `dutPass`=0 on runs 1 and 3 → `failCount`=2, `wasSuccessful`=0, `isRunning` falls after 20 active cycles.
- `TIMEOUT`=8, model never raises `dutDone` on run 2 → `timedOut`=1, `failCount`=1, `runIndex`=2, DONE after 8 WAIT cycles, no further `dutStart`. A `dutDone` injected exactly on WAIT cycle 8 of a separate run → no timeout, run counted normally.
- `doRun` dropped in WAIT of run 1 → IDLE next cycle, `wasSuccessful`=0, `isRunning`=0. `doRun` held high across DONE → no restart until it toggles low then high; the new campaign clears the counters.
